// File: rtl/dwc_result_writer_if.sv
// AXI4-Lite write/read bundle between the result writer (master) and the DWC register slave.
interface dwc_result_writer_if #(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32
);
  logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR;
  logic                          M_AXI_AWVALID;
  logic                          M_AXI_AWREADY;
  logic [31:0]                   M_AXI_WDATA;
  logic [3:0]                    M_AXI_WSTRB;
  logic                          M_AXI_WVALID;
  logic                          M_AXI_WREADY;
  logic [1:0]                    M_AXI_BRESP;
  logic                          M_AXI_BVALID;
  logic                          M_AXI_BREADY;
  logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR;
  logic                          M_AXI_ARVALID;
  logic                          M_AXI_ARREADY;
  logic [31:0]                   M_AXI_RDATA;
  logic [1:0]                    M_AXI_RRESP;
  logic                          M_AXI_RVALID;
  logic                          M_AXI_RREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    output M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY,
    input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID
  );

  modport slave (
    input  M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    input  M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY,
    output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID
  );
endinterface

// File: rtl/dwc_result_writer.sv
// Publishes core result words round-robin into C_NUM_REGS DWC registers over AXI4-Lite.
// Define DWC_WRITER_READBACK_EN to read each register back after its write and compare.
module dwc_result_writer #(
  parameter int unsigned                   C_M_AXI_ADDR_WIDTH = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR        = C_M_AXI_ADDR_WIDTH'(32'h0000_0000),
  parameter int unsigned                   C_NUM_REGS         = 4
) (
  input  logic                M_AXI_ACLK,
  input  logic                M_AXI_ARESET,
  input  logic [31:0]         res_data,
  input  logic                res_valid,
  output logic                res_ready,
  output logic                wr_done,
  output logic                err,
  dwc_result_writer_if.master m_axi
);

  localparam int unsigned IdxW = $clog2(C_NUM_REGS);

  typedef enum logic [2:0] {
    StIdle,
    StWaddrData,
`ifdef DWC_WRITER_READBACK_EN
    StWresp,
    StRaddr,
    StRdata
`else
    StWresp
`endif
  } state_e;

  state_e                        state_q, state_d;
  logic [IdxW-1:0]               idx_q, idx_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [31:0]                   wdata_q, wdata_d;
  logic                          awvalid_q, awvalid_d;
  logic                          wvalid_q, wvalid_d;
  logic                          wr_done_q, wr_done_d;
  logic                          err_q, err_d;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    wr_done_d = 1'b0;
    err_d     = err_q;

    case (state_q)
      StIdle: begin
        if (res_valid) begin
          state_d   = StWaddrData;
          wdata_d   = res_data;
          awaddr_d  = C_BASE_ADDR + C_M_AXI_ADDR_WIDTH'({idx_q, 2'b00});
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
        end
      end
      StWaddrData: begin
        // AW and W retire independently; leave once neither is still outstanding.
        if (m_axi.M_AXI_AWREADY) awvalid_d = 1'b0;
        if (m_axi.M_AXI_WREADY)  wvalid_d  = 1'b0;
        if ((!awvalid_q || m_axi.M_AXI_AWREADY) && (!wvalid_q || m_axi.M_AXI_WREADY)) begin
          state_d = StWresp;
        end
      end
      StWresp: begin
        if (m_axi.M_AXI_BVALID) begin
          idx_d = (idx_q == IdxW'(C_NUM_REGS - 1)) ? '0 : idx_q + 1'b1;
          if (m_axi.M_AXI_BRESP != 2'b00) err_d = 1'b1;
`ifdef DWC_WRITER_READBACK_EN
          state_d = StRaddr;
`else
          state_d   = StIdle;
          wr_done_d = 1'b1;
`endif
        end
      end
`ifdef DWC_WRITER_READBACK_EN
      StRaddr: begin
        if (m_axi.M_AXI_ARREADY) state_d = StRdata;
      end
      StRdata: begin
        if (m_axi.M_AXI_RVALID) begin
          if (m_axi.M_AXI_RDATA != wdata_q || m_axi.M_AXI_RRESP != 2'b00) err_d = 1'b1;
          state_d   = StIdle;
          wr_done_d = 1'b1;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      wr_done_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      wr_done_q <= wr_done_d;
      err_q     <= err_d;
    end
  end

  // Gated by reset so res_ready drops the instant reset asserts, not just after the state clears.
  assign res_ready           = (state_q == StIdle) && !M_AXI_ARESET;
  assign wr_done             = wr_done_q;
  assign err                 = err_q;
  assign m_axi.M_AXI_AWADDR  = awaddr_q;
  assign m_axi.M_AXI_AWVALID = awvalid_q;
  assign m_axi.M_AXI_WDATA   = wdata_q;
  assign m_axi.M_AXI_WSTRB   = 4'hF;
  assign m_axi.M_AXI_WVALID  = wvalid_q;
  assign m_axi.M_AXI_BREADY  = (state_q == StWresp);

`ifdef DWC_WRITER_READBACK_EN
  assign m_axi.M_AXI_ARADDR  = awaddr_q;
  assign m_axi.M_AXI_ARVALID = (state_q == StRaddr);
  assign m_axi.M_AXI_RREADY  = (state_q == StRdata);
`else
  assign m_axi.M_AXI_ARADDR  = '0;
  assign m_axi.M_AXI_ARVALID = 1'b0;
  assign m_axi.M_AXI_RREADY  = 1'b0;

  logic unused_rd;
  assign unused_rd = ^{m_axi.M_AXI_ARREADY, m_axi.M_AXI_RDATA, m_axi.M_AXI_RRESP,
                       m_axi.M_AXI_RVALID};
`endif

endmodule
